// File: rtl/padding_stream_pkg.sv
// Shared defaults, frame-flag payload and helpers for the zero/constant padding stream.
package padding_stream_pkg;

  localparam int unsigned FEATURE_BITWIDTH_DEF = 8;
  localparam int unsigned IMAGE_WIDTH_DEF      = 28;
  localparam int unsigned IMAGE_HEIGHT_DEF     = 28;
  localparam int unsigned PADDING_SIZE_DEF     = 1;
  localparam int unsigned CHANNELS_DEF         = 1;
  localparam int unsigned PADDED_WIDTH_DEF     = IMAGE_WIDTH_DEF + 2 * PADDING_SIZE_DEF;
  localparam int unsigned PADDED_HEIGHT_DEF    = IMAGE_HEIGHT_DEF + 2 * PADDING_SIZE_DEF;

  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } frame_flags_t;

  // Counter width for a range of n values, never narrower than one bit.
  function automatic int unsigned coord_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pad_coord_counter.sv
// Raster row/col position of the next padded output pixel; advances on each output load.
module pad_coord_counter
  import padding_stream_pkg::*;
#(
  parameter int unsigned PW = PADDED_WIDTH_DEF,
  parameter int unsigned PH = PADDED_HEIGHT_DEF,
  localparam int unsigned CW = coord_width(PW),
  localparam int unsigned RW = coord_width(PH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          first_c,
  output logic          last_col_c,
  output logic          last_pix_c
);

  assign first_c    = (row == '0) && (col == '0);
  assign last_col_c = (col == CW'(PW - 1));
  assign last_pix_c = last_col_c && (row == RW'(PH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (last_col_c) begin
        col <= '0;
        row <= last_pix_c ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/padding_stream.sv
// Adds a constant-valued border around a raster pixel stream with valid/ready on both sides.
module padding_stream
  import padding_stream_pkg::*;
#(
  parameter int unsigned FEATURE_BITWIDTH = FEATURE_BITWIDTH_DEF,
  parameter int unsigned IMAGE_WIDTH      = IMAGE_WIDTH_DEF,
  parameter int unsigned IMAGE_HEIGHT     = IMAGE_HEIGHT_DEF,
  parameter int unsigned PADDING_SIZE     = PADDING_SIZE_DEF,
  parameter int unsigned CHANNELS         = CHANNELS_DEF,
  localparam int unsigned DW = CHANNELS * FEATURE_BITWIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [FEATURE_BITWIDTH-1:0] pad_value,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DW-1:0]               in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DW-1:0]               out_data,
  output logic                        out_sof,
  output logic                        out_eol,
  output logic                        out_eof
);

  localparam int unsigned PW = IMAGE_WIDTH + 2 * PADDING_SIZE;
  localparam int unsigned PH = IMAGE_HEIGHT + 2 * PADDING_SIZE;
  localparam int unsigned CW = coord_width(PW);
  localparam int unsigned RW = coord_width(PH);

  logic [RW-1:0]               row;
  logic [CW-1:0]               col;
  logic                        first_c;
  logic                        last_col_c;
  logic                        last_pix_c;
  logic                        border;
  logic                        out_free;
  logic                        load;
  logic [FEATURE_BITWIDTH-1:0] pad_q;
  logic [FEATURE_BITWIDTH-1:0] pad_eff;
  frame_flags_t                flags_q;

  pad_coord_counter #(
    .PW(PW),
    .PH(PH)
  ) u_coord (
    .clk       (clk),
    .rst       (rst),
    .en        (load),
    .row       (row),
    .col       (col),
    .first_c   (first_c),
    .last_col_c(last_col_c),
    .last_pix_c(last_pix_c)
  );

  // Without padding every position is interior; the range checks would degenerate.
  generate
    if (PADDING_SIZE == 0) begin : g_nopad
      assign border = 1'b0;
    end else begin : g_pad
      assign border = (row < RW'(PADDING_SIZE)) ||
                      (row >= RW'(IMAGE_HEIGHT + PADDING_SIZE)) ||
                      (col < CW'(PADDING_SIZE)) ||
                      (col >= CW'(IMAGE_WIDTH + PADDING_SIZE));
    end
  endgenerate

  assign out_free = !out_valid || out_ready;
  assign in_ready = !rst && !border && out_free;
  assign load     = !rst && out_free && (border || in_valid);

  // The first pixel of a frame uses the live pad_value; the rest of the frame uses the sampled copy.
  assign pad_eff  = first_c ? pad_value : pad_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      flags_q   <= '0;
      pad_q     <= '0;
    end else if (load) begin
      out_valid   <= 1'b1;
      out_data    <= border ? {CHANNELS{pad_eff}} : in_data;
      flags_q.sof <= first_c;
      flags_q.eol <= last_col_c;
      flags_q.eof <= last_pix_c;
      if (first_c) begin
        pad_q <= pad_value;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_sof = flags_q.sof;
  assign out_eol = flags_q.eol;
  assign out_eof = flags_q.eof;

endmodule

// File: tb/tb_padding_stream.sv
// Self-checking bench for padding_stream: three configurations against a raster-order reference model.
module tb_padding_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  pad_value = 8'h00;
  logic        in_valid = 1'b0;
  logic [23:0] in_data = 24'h0;
  logic        out_ready = 1'b0;

  logic        a_ir, a_ov, a_sof, a_eol, a_eof;
  logic [7:0]  a_od;
  logic        b_ir, b_ov, b_sof, b_eol, b_eof;
  logic [23:0] b_od;
  logic        c_ir, c_ov, c_sof, c_eol, c_eof;
  logic [7:0]  c_od;

  logic        o_valid, o_sof, o_eol, o_eof, o_in_ready;
  logic [23:0] o_data;

  int total = 0;
  int bad = 0;
  int sel = 0;

  int cfg_w[3] = '{2, 3, 4};
  int cfg_h[3] = '{2, 3, 1};
  int cfg_p[3] = '{1, 2, 0};
  int cfg_c[3] = '{1, 3, 1};

  logic [23:0] in_src[$];
  logic [23:0] in_q[$];
  logic [7:0]  pads[$];
  logic [26:0] obs_q[$];
  logic [26:0] exp_q[$];
  int          obs_cyc[$];
  int          acc_cyc[$];

  always #5 clk = ~clk;

  padding_stream #(.FEATURE_BITWIDTH(8), .IMAGE_WIDTH(2), .IMAGE_HEIGHT(2),
                   .PADDING_SIZE(1), .CHANNELS(1)) dut_a (
    .clk(clk), .rst(rst), .pad_value(pad_value), .in_valid(in_valid), .in_ready(a_ir),
    .in_data(in_data[7:0]), .out_valid(a_ov), .out_ready(out_ready), .out_data(a_od),
    .out_sof(a_sof), .out_eol(a_eol), .out_eof(a_eof));

  padding_stream #(.FEATURE_BITWIDTH(8), .IMAGE_WIDTH(3), .IMAGE_HEIGHT(3),
                   .PADDING_SIZE(2), .CHANNELS(3)) dut_b (
    .clk(clk), .rst(rst), .pad_value(pad_value), .in_valid(in_valid), .in_ready(b_ir),
    .in_data(in_data), .out_valid(b_ov), .out_ready(out_ready), .out_data(b_od),
    .out_sof(b_sof), .out_eol(b_eol), .out_eof(b_eof));

  padding_stream #(.FEATURE_BITWIDTH(8), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(1),
                   .PADDING_SIZE(0), .CHANNELS(1)) dut_c (
    .clk(clk), .rst(rst), .pad_value(pad_value), .in_valid(in_valid), .in_ready(c_ir),
    .in_data(in_data[7:0]), .out_valid(c_ov), .out_ready(out_ready), .out_data(c_od),
    .out_sof(c_sof), .out_eol(c_eol), .out_eof(c_eof));

  // View of whichever configuration is under test.
  always_comb begin
    o_valid = a_ov; o_data = 24'(a_od); o_sof = a_sof; o_eol = a_eol; o_eof = a_eof;
    o_in_ready = a_ir;
    if (sel == 1) begin
      o_valid = b_ov; o_data = b_od; o_sof = b_sof; o_eol = b_eol; o_eof = b_eof;
      o_in_ready = b_ir;
    end else if (sel == 2) begin
      o_valid = c_ov; o_data = 24'(c_od); o_sof = c_sof; o_eol = c_eol; o_eof = c_eof;
      o_in_ready = c_ir;
    end
  end

  task automatic apply_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic gen_inputs(input int n);
    logic [23:0] mask;
    mask = (cfg_c[sel] == 3) ? 24'hFFFFFF : 24'h0000FF;
    in_src.delete();
    for (int i = 0; i < n; i++) in_src.push_back(24'($urandom) & mask);
    in_q = in_src;
  endtask

  // Reference: walk the padded frame, border pixels from pads[f], interior from the input list in order.
  task automatic build_expected(input int frames);
    int w, h, p, pw, ph, nch, k;
    logic [23:0] d;
    bit brd;
    w = cfg_w[sel]; h = cfg_h[sel]; p = cfg_p[sel]; nch = cfg_c[sel];
    pw = w + 2 * p; ph = h + 2 * p; k = 0;
    exp_q.delete();
    for (int f = 0; f < frames; f++)
      for (int r = 0; r < ph; r++)
        for (int c = 0; c < pw; c++) begin
          d = 24'h0;
          brd = (r < p) || (r >= h + p) || (c < p) || (c >= w + p);
          if (brd) begin
            for (int ch = 0; ch < nch; ch++) d[ch*8 +: 8] = pads[f];
          end else begin
            d = in_src[k];
            k++;
          end
          exp_q.push_back({(r == 0 && c == 0), (c == pw - 1), (r == ph - 1 && c == pw - 1), d});
        end
  endtask

  // Drives inputs/out_ready, records transfers; pad_value follows the count of frames started.
  task automatic run_stream(input int frames, input bit stall, input bit gap, input int stop_after);
    int t, sofs, target, pw, ph;
    bit held;
    logic [26:0] hold_v;
    t = 0; sofs = 0; held = 1'b0; hold_v = '0;
    pw = cfg_w[sel] + 2 * cfg_p[sel];
    ph = cfg_h[sel] + 2 * cfg_p[sel];
    target = (stop_after > 0) ? stop_after : frames * pw * ph;
    obs_q.delete(); obs_cyc.delete(); acc_cyc.delete();
    while (obs_q.size() < target && t < 4000) begin
      in_valid  = (in_q.size() > 0) && (!gap || ($urandom_range(0, 2) != 0));
      in_data   = (in_q.size() > 0) ? in_q[0] : 24'h0;
      out_ready = stall ? (t % 2 == 0) : 1'b1;
      pad_value = (sofs < pads.size()) ? pads[sofs] : 8'h00;
      @(negedge clk);
      if (held) begin
        total++;
        if (o_valid !== 1'b1 || {o_sof, o_eol, o_eof, o_data} !== hold_v) begin
          bad++;
          $display("FAIL stall_hold t=%0d got valid=%b %h want valid=1 %h", t, o_valid,
                   {o_sof, o_eol, o_eof, o_data}, hold_v);
        end
      end
      held = 1'b0;
      if (in_valid && o_in_ready) begin
        void'(in_q.pop_front());
        acc_cyc.push_back(t);
      end
      if (o_valid && out_ready) begin
        obs_q.push_back({o_sof, o_eol, o_eof, o_data});
        obs_cyc.push_back(t);
        if (o_sof) sofs++;
      end else if (o_valid) begin
        held = 1'b1;
        hold_v = {o_sof, o_eol, o_eof, o_data};
      end
      @(posedge clk);
      #1 t++;
    end
    if (obs_q.size() < target) begin
      total++; bad++;
      $display("FAIL timeout got %0d outputs want %0d", obs_q.size(), target);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      total++;
      if ({a_ov, a_od, a_sof, a_eol, a_eof, a_ir} !== 13'h0) begin
        bad++; $display("FAIL reset_a got %h want 0", {a_ov, a_od, a_sof, a_eol, a_eof, a_ir});
      end
      total++;
      if ({b_ov, b_od, b_sof, b_eol, b_eof, b_ir} !== 29'h0) begin
        bad++; $display("FAIL reset_b got %h want 0", {b_ov, b_od, b_sof, b_eol, b_eof, b_ir});
      end
      total++;
      if ({c_ov, c_od, c_sof, c_eol, c_eof, c_ir} !== 13'h0) begin
        bad++; $display("FAIL reset_c got %h want 0", {c_ov, c_od, c_sof, c_eol, c_eof, c_ir});
      end
    end
    #1 rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_basic();
    sel = 0; apply_reset();
    in_src = '{24'd1, 24'd2, 24'd3, 24'd4}; in_q = in_src;
    pads = '{8'h00, 8'h00};
    run_stream(1, 1'b0, 1'b0, 0);
    build_expected(1);
    for (int i = 0; i < 16; i++) begin
      total++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL basic[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    total++;
    if (obs_q.size() == 16 && obs_cyc[15] - obs_cyc[0] != 15) begin
      bad++; $display("FAIL basic_throughput got span %0d want 15", obs_cyc[15] - obs_cyc[0]);
    end
  endtask

  task automatic test_stall();
    sel = 0; apply_reset();
    gen_inputs(8);
    pads = '{8'($urandom), 8'($urandom), 8'h00};
    run_stream(2, 1'b1, 1'b1, 0);
    build_expected(2);
    for (int i = 0; i < 32; i++) begin
      total++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL stall[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    total++;
    if (in_q.size() != 0) begin
      bad++; $display("FAIL stall_inputs got %0d left want 0", in_q.size());
    end
  endtask

  task automatic test_back_to_back();
    sel = 0; apply_reset();
    gen_inputs(8);
    pads = '{8'hFF, 8'h00, 8'h00};
    run_stream(2, 1'b0, 1'b0, 0);
    build_expected(2);
    for (int i = 0; i < 32; i++) begin
      total++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL b2b[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    total++;
    if (obs_q.size() == 32 && obs_cyc[16] != obs_cyc[15] + 1) begin
      bad++; $display("FAIL b2b_gap got cycle %0d want %0d", obs_cyc[16], obs_cyc[15] + 1);
    end
  endtask

  task automatic test_multichannel();
    sel = 1; apply_reset();
    gen_inputs(9);
    pads = '{8'($urandom), 8'h00};
    run_stream(1, 1'b0, 1'b0, 0);
    build_expected(1);
    for (int i = 0; i < 49; i++) begin
      total++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL mc[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    apply_reset();
    gen_inputs(18);
    pads = '{8'($urandom), 8'($urandom), 8'h00};
    run_stream(2, 1'b1, 1'b1, 0);
    build_expected(2);
    for (int i = 0; i < 98; i++) begin
      total++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL mc_stall[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    sel = 0; apply_reset();
    gen_inputs(4);
    pads = '{8'h5A, 8'h5A};
    run_stream(1, 1'b0, 1'b0, 7);
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      total++;
      if ({a_ov, a_od, a_sof, a_eol, a_eof, a_ir} !== 13'h0) begin
        bad++; $display("FAIL reset_mid got %h want 0", {a_ov, a_od, a_sof, a_eol, a_eof, a_ir});
      end
    end
    @(posedge clk);
    #1 rst = 1'b0; in_valid = 1'b0;
    gen_inputs(4);
    pads = '{8'($urandom), 8'h00};
    run_stream(1, 1'b0, 1'b0, 0);
    build_expected(1);
    for (int i = 0; i < 16; i++) begin
      total++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL after_reset[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_passthrough();
    sel = 2; apply_reset();
    in_src = '{24'd10, 24'd11, 24'd12, 24'd13}; in_q = in_src;
    pads = '{8'h77, 8'h77};
    run_stream(1, 1'b0, 1'b0, 0);
    build_expected(1);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL pass[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
      end
      total++;
      if (i >= obs_cyc.size() || i >= acc_cyc.size() || obs_cyc[i] != acc_cyc[i] + 1) begin
        bad++; $display("FAIL pass_latency[%0d] got out cycle %0d want %0d", i, obs_cyc[i],
                        acc_cyc[i] + 1);
      end
    end
    apply_reset();
    gen_inputs(12);
    pads = '{8'h00, 8'h00, 8'h00, 8'h00};
    run_stream(3, 1'b1, 1'b1, 0);
    build_expected(3);
    for (int i = 0; i < 12; i++) begin
      total++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL pass_stall[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_multichannel();
    test_reset_mid();
    test_passthrough();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/padding_stream.md
PADDING_STREAM -- requirements
Module: padding_stream

Interface
REQ-001 Parameter FEATURE_BITWIDTH, default 8: bits per channel element.
REQ-002 Parameter IMAGE_WIDTH, default 28: unpadded columns per frame.
REQ-003 Parameter IMAGE_HEIGHT, default 28: unpadded rows per frame.
REQ-004 Parameter PADDING_SIZE, default 1: border pixels added on each side; 0 is legal.
REQ-005 Parameter CHANNELS, default 1: channels carried in parallel per pixel.
REQ-006 Port clk, input, 1: single clock; all logic on the rising edge.
REQ-007 Port rst, input, 1: synchronous, active-high reset.
REQ-008 Port pad_value, input, FEATURE_BITWIDTH: border element value, replicated to all channels; sampled at the first output pixel of each frame.
REQ-009 Port in_valid, input, 1: in_data holds an unpadded pixel.
REQ-010 Port in_ready, output, 1: block accepts in_data this cycle.
REQ-011 Port in_data, input, CHANNELS*FEATURE_BITWIDTH: raster-order pixel, channel 0 in the LSBs.
REQ-012 Port out_valid, output, 1: out_data holds a padded pixel.
REQ-013 Port out_ready, input, 1: downstream accepts out_data.
REQ-014 Port out_data, output, CHANNELS*FEATURE_BITWIDTH: raster-order padded pixel.
REQ-015 Port out_sof, output, 1: out_data is padded pixel (0,0).
REQ-016 Port out_eol, output, 1: out_data is the last column of a padded row.
REQ-017 Port out_eof, output, 1: out_data is the last padded pixel of the frame.

Function
REQ-018 PW = IMAGE_WIDTH+2*PADDING_SIZE and PH = IMAGE_HEIGHT+2*PADDING_SIZE; every frame emits exactly PW*PH pixels in raster order.
REQ-019 Output coordinates row (0..PH-1) and col (0..PW-1) advance only on an output load; col wraps to 0 and row increments at col=PW-1; both wrap to 0 after (PH-1,PW-1), and the next frame starts on the following load with no idle cycle.
REQ-020 Position is border when row<P, row>=IMAGE_HEIGHT+P, col<P, or col>=IMAGE_WIDTH+P (P = PADDING_SIZE); otherwise it is interior.
REQ-021 out_free = !out_valid || out_ready; the output register loads only when out_free.
REQ-022 Border position: when out_free, load pad_value into every channel, set out_valid; in_ready=0; no input consumed.
REQ-023 Interior position: in_ready = out_free; on in_valid && in_ready, load in_data unchanged; if !in_valid, hold the output register and the counters.
REQ-024 out_data, out_sof, out_eol and out_eof are registered, change only on a load, and stay stable while out_valid && !out_ready.
REQ-025 Latency from an accepted input to out_valid of that pixel is 1 cycle; throughput is 1 pixel/cycle when in_valid and out_ready stay high.
REQ-026 in_ready is combinational from out_valid, out_ready and the coordinates, and does not depend on in_valid.
REQ-027 The pad_value sampled for a frame is used for all border pixels of that frame; changes mid-frame are ignored.
REQ-028 With PADDING_SIZE=0 the block is a 1-stage registered pass-through with correct sof/eol/eof.
REQ-029 Counter widths are $clog2 of PW and PH, each at least 1 bit; coordinates never take values outside range.

Reset
REQ-030 When rst is sampled high: out_valid=0, out_data=0, out_sof=0, out_eol=0, out_eof=0, row=0, col=0, and the stored pad_value=0; in_ready is 0 during reset.
REQ-031 A reset mid-frame discards the partial frame; the first load after reset is padded pixel (0,0) with out_sof=1.

Structure
REQ-032 FEATURE_BITWIDTH, IMAGE_WIDTH, IMAGE_HEIGHT, PADDING_SIZE and the derived PADDED_WIDTH/PADDED_HEIGHT defaults belong in cnn_layer_1_define.vh; the module parameters default to those values.
REQ-033 The raster row/col counter with eol/eof flags is one sub-module, pad_coord_counter, parameterised by PW/PH and enabled by the load strobe.

Verification
REQ-034 W=H=2, P=1, C=1, pad_value=0, inputs 1,2,3,4, out_ready=1 -> 16 outputs 0,0,0,0,0,1,2,0,0,3,4,0,0,0,0,0; sof on output 0, eol on outputs 3,7,11,15, eof on output 15.
REQ-035 Same setup, out_ready toggled 1/0 each cycle and in_valid gapped -> identical sequence; out_data held stable while stalled; no input dropped or duplicated.
REQ-036 W=H=2, P=1, pad_value=8'hFF set before frame 1 and 8'h00 before frame 2, frames back to back -> frame 1 borders 0xFF, frame 2 borders 0x00; no idle cycle between eof and the next sof.
REQ-037 C=3, W=H=3, P=2 -> 49 outputs per frame; the interior 3x3 block at rows/cols 2..4 carries the inputs with all 3 channels intact.
REQ-038 Reset asserted after 7 outputs of a W=H=2, P=1 frame -> all outputs 0 during reset; after release a full 16-pixel frame is emitted starting with sof.
REQ-039 W=4, H=1, P=0, inputs 10,11,12,13 -> outputs 10,11,12,13 at 1-cycle latency; eol and eof on 13.
